// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_instr_encoder
// Description : Assembles 32-bit MIPS instruction words from class + field
//               requests, buffers them in a small FIFO and streams them into
//               instruction memory at auto-incrementing word addresses.
//               Optional illegal-request checking is enabled by defining
//               MIPS_ENC_CHECK_EN; without it illegal kinds encode as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int DEPTH = 4,    // FIFO entries, power of 2, >= 2
    parameter int AW    = 6,    // imem word-address width
    parameter int BASE  = 0     // first imem word address after reset/start
) (
    input  logic          clk,
    input  logic          reset,        // asynchronous, active-low
    input  logic          start,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_kind,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_rd,
    input  logic [5:0]    req_funct,
    input  logic [15:0]   req_imm,
    input  logic [25:0]   req_target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [AW-1:0] c_base    = AW'(BASE);
    localparam logic [AW:0]   c_cnt_max = {1'b1, {AW{1'b0}}};
    localparam logic [PW:0]   c_full    = (PW+1)'(DEPTH);

    // Request classes
    localparam logic [2:0] c_kind_rtype = 3'd0;
    localparam logic [2:0] c_kind_lw    = 3'd1;
    localparam logic [2:0] c_kind_sw    = 3'd2;
    localparam logic [2:0] c_kind_beq   = 3'd3;
    localparam logic [2:0] c_kind_addi  = 3'd4;
    localparam logic [2:0] c_kind_j     = 3'd5;

    // Primary opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // FIFO storage and pointers
    logic [31:0]   r_mem_q [DEPTH];
    logic [PW-1:0] r_wr_ptr_q;
    logic [PW-1:0] r_rd_ptr_q;
    logic [PW:0]   r_occ_q;
    logic [PW:0]   r_occ_d;

    // Write stage state
    logic          r_we_q;
    logic [AW-1:0] r_addr_q;
    logic [31:0]   r_wd_q;
    logic [AW-1:0] r_wptr_q;
    logic [AW:0]   r_count_q;

    logic [31:0]   w_enc;
    logic          w_illegal;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign req_ready = (r_occ_q != c_full);
    assign w_accept  = req_valid & req_ready;
    assign w_push    = w_accept & ~w_illegal;
    // The write stage yields to start so the rewind edge never emits a word
    assign w_pop     = (r_occ_q != '0) & ~start;

    // Assemble the instruction word for the requested class (shamt always 0)
    always_comb begin
        w_enc = 32'h0000_0000;
        case (req_kind)
            c_kind_rtype: w_enc = {c_op_rtype, req_rs, req_rt, req_rd, 5'b00000, req_funct};
            c_kind_lw:    w_enc = {c_op_lw,    req_rs, req_rt, req_imm};
            c_kind_sw:    w_enc = {c_op_sw,    req_rs, req_rt, req_imm};
            c_kind_beq:   w_enc = {c_op_beq,   req_rs, req_rt, req_imm};
            c_kind_addi:  w_enc = {c_op_addi,  req_rs, req_rt, req_imm};
            c_kind_j:     w_enc = {c_op_j,     req_target};
            default:      w_enc = 32'h0000_0000;   // kinds 6/7 encode as NOP
        endcase
    end

`ifdef MIPS_ENC_CHECK_EN
    // Flag unsupported classes and R-type functions outside the core's ALU set
    always_comb begin
        w_illegal = 1'b0;
        if (req_kind > c_kind_j) begin
            w_illegal = 1'b1;
        end else if (req_kind == c_kind_rtype) begin
            case (req_funct)
                6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010: w_illegal = 1'b0;
                default:              w_illegal = 1'b1;
            endcase
        end
    end

    logic r_err_q;

    // Sticky error; start clears it even if an illegal request lands the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_q <= 1'b0;
        end else if (start) begin
            r_err_q <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err_q <= 1'b1;
        end
    end

    assign err = r_err_q;
`else
    assign w_illegal = 1'b0;
    assign err       = 1'b0;
`endif

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged
    always_comb begin
        r_occ_d = r_occ_q + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end

    // FIFO payload storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= w_enc;
        end
    end

    // FIFO pointers and occupancy; reset discards all pending words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_occ_q    <= '0;
        end else begin
            r_occ_q <= r_occ_d;
            if (w_push) begin
                r_wr_ptr_q <= r_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr_q <= r_rd_ptr_q + 1'b1;
            end
        end
    end

    // Write stage: drain the FIFO head into imem, start rewinds the address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we_q    <= 1'b0;
            r_addr_q  <= c_base;
            r_wd_q    <= 32'h0000_0000;
            r_wptr_q  <= c_base;
            r_count_q <= '0;
        end else if (start) begin
            r_we_q    <= 1'b0;
            r_wptr_q  <= c_base;
            r_count_q <= '0;
        end else if (w_pop) begin
            r_we_q   <= 1'b1;
            r_addr_q <= r_wptr_q;
            r_wd_q   <= r_mem_q[r_rd_ptr_q];
            r_wptr_q <= r_wptr_q + 1'b1;        // wraps 2**AW-1 -> 0
            if (r_count_q != c_cnt_max) begin
                r_count_q <= r_count_q + 1'b1;
            end
        end else begin
            r_we_q <= 1'b0;
        end
    end

    assign imem_we   = r_we_q;
    assign imem_addr = r_addr_q;
    assign imem_wd   = r_wd_q;
    assign count     = r_count_q;
    assign busy      = (r_occ_q != '0) | r_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_instr_encoder
// Description : Directed self-checking bench for mips_instr_encoder with
//               hand-computed instruction words and imem write capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int BASE  = 0;

    logic          clk;
    logic          reset;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_kind;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [5:0]    req_funct;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic [AW:0]   count;
    logic          busy;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;

    // Captured imem writes
    logic [AW-1:0] cap_addr [256];
    logic [31:0]   cap_wd   [256];
    int            cap_n = 0;

    mips_instr_encoder #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .BASE  (BASE)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_funct  (req_funct),
        .req_imm    (req_imm),
        .req_target (req_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .count      (count),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every imem write mid-cycle
    always @(negedge clk) begin
        if (imem_we && cap_n < 256) begin
            cap_addr[cap_n] = imem_addr;
            cap_wd[cap_n]   = imem_wd;
            cap_n           = cap_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tg);
        int guard;
        guard      = 0;
        req_kind   = k;
        req_rs     = rs;
        req_rt     = rt;
        req_rd     = rd;
        req_funct  = fn;
        req_imm    = imm;
        req_target = tg;
        req_valid  = 1'b1;
        while (!req_ready && guard < 50) begin
            step();
            guard = guard + 1;
        end
        if (!req_ready) check_eq("send_timeout", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    int c0;

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        req_valid  = 1'b0;
        req_kind   = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_rd     = '0;
        req_funct  = '0;
        req_imm    = '0;
        req_target = '0;

        // ---- reset state ----
        wait_cycles(3);
        check_eq("rst_we",    64'(imem_we),   64'd0);
        check_eq("rst_addr",  64'(imem_addr), 64'(BASE));
        check_eq("rst_wd",    64'(imem_wd),   64'd0);
        check_eq("rst_count", 64'(count),     64'd0);
        check_eq("rst_busy",  64'(busy),      64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_err",   64'(err),       64'd0);
        reset = 1'b1;
        wait_cycles(2);

        // ---- single ADDI rs=0 rt=8 imm=5 with latency check ----
        c0 = cap_n;
        send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
        check_eq("lat_we_k",   64'(imem_we), 64'd0);
        check_eq("lat_busy_k", 64'(busy),    64'd1);
        step();
        check_eq("lat_we_k1",  64'(imem_we), 64'd1);
        wait_cycles(3);
        check_eq("addi_n",     64'(cap_n - c0),   64'd1);
        check_eq("addi_addr",  64'(cap_addr[c0]), 64'(BASE));
        check_eq("addi_wd",    64'(cap_wd[c0]),   64'h2008_0005);
        check_eq("addi_count", 64'(count),        64'd1);
        check_eq("addi_busy",  64'(busy),         64'd0);

        // ---- back-to-back RTYPE add, LW, J after rewind ----
        pulse_start();
        check_eq("start_count", 64'(count), 64'd0);
        c0 = cap_n;
        send(3'd0, 5'd8,  5'd9, 5'd10, 6'b100000, 16'hFFFF, 26'h3FFFFFF);
        send(3'd1, 5'd29, 5'd8, 5'd31, 6'h3F,     16'd4,    26'h3FFFFFF);
        send(3'd5, 5'd31, 5'd31, 5'd31, 6'h3F,    16'hFFFF, 26'h0100000);
        wait_cycles(4);
        check_eq("b2b_n",     64'(cap_n - c0),     64'd3);
        check_eq("b2b_wd0",   64'(cap_wd[c0]),     64'h0109_5020);
        check_eq("b2b_wd1",   64'(cap_wd[c0 + 1]), 64'h8FA8_0004);
        check_eq("b2b_wd2",   64'(cap_wd[c0 + 2]), 64'h0810_0000);
        check_eq("b2b_addr0", 64'(cap_addr[c0]),     64'(BASE));
        check_eq("b2b_addr2", 64'(cap_addr[c0 + 2]), 64'(BASE + 2));
        check_eq("b2b_count", 64'(count), 64'd3);

        // ---- stall with start every cycle, fill FIFO ----
        c0    = cap_n;
        start = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(3'd2, 5'd1, 5'(i), 5'd0, 6'd0, 16'(16'h0010 + i), 26'd0);
        end
        check_eq("full_ready", 64'(req_ready), 64'd0);
        check_eq("full_we",    64'(imem_we),   64'd0);
        check_eq("full_busy",  64'(busy),      64'd1);
        start = 1'b0;
        step();
        check_eq("drain_ready", 64'(req_ready), 64'd1);
        wait_cycles(6);
        check_eq("drain_n", 64'(cap_n - c0), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            // SW rs=1 rt=i imm=0x10+i: 101011 00001 rt imm
            check_eq("drain_wd",   64'(cap_wd[c0 + i]),
                     64'(32'hAC20_0000 | (32'(i) << 16) | (32'h10 + 32'(i))));
            check_eq("drain_addr", 64'(cap_addr[c0 + i]), 64'(BASE + i));
        end
        check_eq("drain_count", 64'(count), 64'd4);

        // ---- address wrap and count saturation ----
        pulse_start();
        c0 = cap_n;
        for (int i = 0; i < 65; i++) begin
            send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'(i), 26'd0);
        end
        wait_cycles(5);
        check_eq("wrap_n",      64'(cap_n - c0),      64'd65);
        check_eq("wrap_addr63", 64'(cap_addr[c0 + 63]), 64'd63);
        check_eq("wrap_addr64", 64'(cap_addr[c0 + 64]), 64'd0);
        check_eq("wrap_wd64",   64'(cap_wd[c0 + 64]),   64'h2008_0040);
        check_eq("wrap_count",  64'(count),             64'd64);

        // ---- illegal kind 7 ----
        pulse_start();
        c0 = cap_n;
        send(3'd7, 5'd3, 5'd4, 5'd5, 6'h3F, 16'h1234, 26'h2AAAAAA);
        wait_cycles(4);
`ifdef MIPS_ENC_CHECK_EN
        check_eq("ill_n",     64'(cap_n - c0), 64'd0);
        check_eq("ill_err",   64'(err),        64'd1);
        check_eq("ill_count", 64'(count),      64'd0);
        pulse_start();
        check_eq("ill_err_clr", 64'(err), 64'd0);
`else
        check_eq("ill_n",     64'(cap_n - c0),   64'd1);
        check_eq("ill_wd",    64'(cap_wd[c0]),   64'd0);
        check_eq("ill_addr",  64'(cap_addr[c0]), 64'(BASE));
        check_eq("ill_err",   64'(err),          64'd0);
        check_eq("ill_count", 64'(count),        64'd1);
`endif

        // ---- reset asserted with words still queued ----
        start = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(3'd4, 5'd2, 5'd3, 5'd0, 6'd0, 16'(16'h0100 + i), 26'd0);
        end
        start = 1'b0;
        step();
        check_eq("pre_rst_we", 64'(imem_we), 64'd1);
        c0    = cap_n;
        reset = 1'b0;
        #1;
        check_eq("arst_we",    64'(imem_we),   64'd0);
        check_eq("arst_busy",  64'(busy),      64'd0);
        check_eq("arst_ready", 64'(req_ready), 64'd1);
        check_eq("arst_count", 64'(count),     64'd0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(10);
        check_eq("post_rst_n",    64'(cap_n - c0), 64'd0);
        check_eq("post_rst_busy", 64'(busy),       64'd0);
        check_eq("post_rst_addr", 64'(imem_addr),  64'(BASE));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
